// File: rtl/and44_preimage_solver.sv
// Inverse of the 4-in/9-out AND product network: scans all 16 assignments.
// Optional known_mask/known_val outputs under `define AND44_PREIMAGE_MASK_EN.
module and44_preimage_solver #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       preimage,
    output logic [CNT_W-1:0] match_cnt,
    output logic             uniq,
`ifdef AND44_PREIMAGE_MASK_EN
    output logic [3:0]       known_mask,
    output logic [3:0]       known_val,
`endif
    output logic             invalid
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state, state_nxt;
    logic [8:0] prod_q;
    logic [3:0] cand;
    logic       found;
    logic       hit;

`ifdef AND44_PREIMAGE_MASK_EN
    logic [3:0] acc_and, acc_or;
`endif

    function automatic logic [8:0] and44(input logic [3:0] x);
        logic a, b, c, d;
        a = x[0];
        b = x[1];
        c = x[2];
        d = x[3];
        return {b & d, b & c, a & d, a & c,
                b & c & d, a & c & d, a & b & d, a & b & c,
                a & b & c & d};
    endfunction

    assign hit = (and44(cand) == prod_q);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = SCAN;
            end
            SCAN: begin
                if (cand == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // First DONE cycle finalises the flags from the completed count,
    // so out_valid rises one edge after the scan ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prod_q    <= '0;
            cand      <= '0;
            found     <= 1'b0;
            out_valid <= 1'b0;
            preimage  <= '0;
            match_cnt <= '0;
            uniq      <= 1'b0;
            invalid   <= 1'b0;
`ifdef AND44_PREIMAGE_MASK_EN
            acc_and    <= '0;
            acc_or     <= '0;
            known_mask <= '0;
            known_val  <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        prod_q    <= prod;
                        cand      <= '0;
                        found     <= 1'b0;
                        match_cnt <= '0;
                        preimage  <= '0;
`ifdef AND44_PREIMAGE_MASK_EN
                        acc_and <= 4'hF;
                        acc_or  <= 4'h0;
`endif
                    end
                end
                SCAN: begin
                    cand <= cand + 4'd1;
                    if (hit) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                        if (!found) begin
                            preimage <= cand;
                            found    <= 1'b1;
                        end
`ifdef AND44_PREIMAGE_MASK_EN
                        acc_and <= acc_and & cand;
                        acc_or  <= acc_or | cand;
`endif
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        uniq      <= (match_cnt == CNT_W'(1));
                        invalid   <= (match_cnt == '0);
`ifdef AND44_PREIMAGE_MASK_EN
                        known_mask <= ~(acc_or ^ acc_and);
                        known_val  <= acc_and & ~(acc_or ^ acc_and);
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and44_preimage_solver.sv
// Scoreboard bench for and44_preimage_solver with directed product words.
module tb_and44_preimage_solver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] prod;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] preimage;
    logic [4:0] match_cnt;
    logic       uniq;
    logic       invalid;
`ifdef AND44_PREIMAGE_MASK_EN
    logic [3:0] known_mask;
    logic [3:0] known_val;
`endif

    always #5 clk = ~clk;

    and44_preimage_solver #(.CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .preimage  (preimage),
        .match_cnt (match_cnt),
        .uniq      (uniq),
`ifdef AND44_PREIMAGE_MASK_EN
        .known_mask(known_mask),
        .known_val (known_val),
`endif
        .invalid   (invalid)
    );

    typedef struct packed {
        logic [4:0] cnt;
        logic [3:0] pre;
        logic       u;
        logic       inv;
        logic [3:0] km;
        logic [3:0] kv;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input int p, input int u,
                                input int i, input int km, input int kv);
        exp_t e;
        e.cnt = 5'(c);
        e.pre = 4'(p);
        e.u   = 1'(u);
        e.inv = 1'(i);
        e.km  = 4'(km);
        e.kv  = 4'(kv);
        return e;
    endfunction

    // Monitor: one pop per completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("match_cnt", int'(match_cnt), int'(e.cnt));
                check("preimage", int'(preimage), int'(e.pre));
                check("uniq", int'(uniq), int'(e.u));
                check("invalid", int'(invalid), int'(e.inv));
`ifdef AND44_PREIMAGE_MASK_EN
                check("known_mask", int'(known_mask), int'(e.km));
                check("known_val", int'(known_val), int'(e.kv));
`endif
            end
        end
    end

    task automatic send(input logic [8:0] p, input exp_t e, input bit push);
        int n;
        @(negedge clk);
        prod     = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", n, 0);
        @(posedge clk);
        if (push) q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", n, 0);
    endtask

    initial begin
        int k;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_match_cnt", int'(match_cnt), 0);
        check("rst_preimage", int'(preimage), 0);
        check("rst_uniq", int'(uniq), 0);
        check("rst_invalid", int'(invalid), 0);
        check("rst_in_ready", int'(in_ready), 1);

        send(9'h000, mk(7, 0, 0, 0, 0, 0), 1);
        send(9'h1FF, mk(1, 15, 1, 0, 15, 15), 1);
        send(9'h020, mk(1, 5, 1, 0, 15, 5), 1);
        send(9'h080, mk(1, 6, 1, 0, 15, 6), 1);
        send(9'h040, mk(1, 9, 1, 0, 15, 9), 1);
        send(9'h100, mk(1, 10, 1, 0, 15, 10), 1);
        drain();

        // Impossible word plus latency measurement.
        send(9'h001, mk(0, 0, 0, 1, 0, 0), 1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, 17);
        drain();

        // Back-pressure hold.
        out_ready = 1'b0;
        send(9'h020, mk(1, 5, 1, 0, 15, 5), 1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("hold_valid_rise", k, 17);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            prod     = 9'h1FF;
            @(posedge clk);
            #1;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_match_cnt", int'(match_cnt), 1);
            check("hold_preimage", int'(preimage), 5);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("after_in_ready", int'(in_ready), 1);
        check("after_match_cnt", int'(match_cnt), 1);
        check("after_preimage", int'(preimage), 5);
        send(9'h040, mk(1, 9, 1, 0, 15, 9), 1);
        drain();

        // Abort during the 8th scan cycle.
        send(9'h1FF, mk(0, 0, 0, 0, 0, 0), 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_match_cnt", int'(match_cnt), 0);
        check("abort_preimage", int'(preimage), 0);
        check("abort_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", int'(in_ready), 1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        send(9'h080, mk(1, 6, 1, 0, 15, 6), 1);
        drain();

        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
